pgm_ram_arb: RTL

Arbiter and sequencer for the single-port PGM program RAM (128 x 144b). Three requesters share the RAM: the PGM write stage (posted writes, no backpressure), the PGM read stage (program fetch), and a DMA-side configuration readback port. A small write FIFO absorbs posted writes. The block enforces read-after-write ordering and routes read data back to the requester that issued the read.

---
 rtl/pgm_pkg.sv | 7 +
 rtl/pgm_wr_fifo.sv | 56 +++++
 rtl/pgm_ram_arb.sv | 114 +++++++++++
 3 files changed

// File: rtl/pgm_pkg.sv
// pgm_pkg: shared widths and enums for the PGM program-RAM arbiter
package pgm_pkg;
  localparam int ADDR_W = 7;
  localparam int DATA_W = 144;
  typedef enum logic [1:0] {TAG_NONE, TAG_RD, TAG_CFG} tag_e;
  typedef enum logic [1:0] {SRC_NONE, SRC_WR, SRC_RD, SRC_CFG} src_e;
endpackage

// File: rtl/pgm_wr_fifo.sv
// pgm_wr_fifo: posted-write FIFO with occupancy count and per-entry address match
// Ports: i_push/i_addr/i_data enqueue, i_pop dequeues the head (o_head_addr/o_head_data),
// o_count occupancy, o_match[i] = entry i valid and holding i_cmp_addr, o_ovf sticky drop flag.
module pgm_wr_fifo #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 144,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_push,
  input  logic [ADDR_W-1:0]       i_addr,
  input  logic [DATA_W-1:0]       i_data,
  input  logic                    i_pop,
  input  logic [ADDR_W-1:0]       i_cmp_addr,
  output logic [ADDR_W-1:0]       o_head_addr,
  output logic [DATA_W-1:0]       o_head_data,
  output logic [$clog2(DEPTH):0]  o_count,
  output logic [DEPTH-1:0]        o_match,
  output logic                    o_ovf
);
  localparam int PW = $clog2(DEPTH);
  logic [ADDR_W-1:0] r_addr [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [PW-1:0] r_rd, r_wr;
  logic [PW:0] r_count;
  logic w_full, w_push, w_pop;
  assign w_full = r_count == (PW+1)'(DEPTH);
  assign w_push = i_push && (!w_full || i_pop);
  assign w_pop = i_pop && r_count != '0;
  assign o_head_addr = r_addr[r_rd];
  assign o_head_data = r_data[r_rd];
  assign o_count = r_count;
  for (genvar g = 0; g < DEPTH; g++) begin : g_match
    logic [PW-1:0] w_off;
    assign w_off = PW'(g) - r_rd;
    assign o_match[g] = ({1'b0, w_off} < r_count) && r_addr[g] == i_cmp_addr;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_rd <= '0;
      r_wr <= '0;
      r_count <= '0;
      o_ovf <= 1'b0;
    end else begin
      if (w_push) r_wr <= r_wr + PW'(1);
      if (w_pop) r_rd <= r_rd + PW'(1);
      r_count <= r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
      if (i_push && !w_push) o_ovf <= 1'b1;
    end
  always_ff @(posedge clk)
    if (w_push) begin
      r_addr[r_wr] <= i_addr;
      r_data[r_wr] <= i_data;
    end
endmodule

// File: rtl/pgm_ram_arb.sv
// pgm_ram_arb: arbiter/sequencer sharing the single-port PGM RAM between writes, fetch and cfg readback
// Ports: wr_in_* posted writes (wr_alf, wr_ovf_err), rd_req/rd_addr -> rd_gnt/rd_rvalid,
// cfg_rd_req/cfg_rd_addr -> cfg_rd_gnt/cfg_rvalid, shared rdata, registered ram_* interface.
// Optional: define PGM_ARB_STAT_EN to add stat_wr_cnt/stat_rd_cnt/stat_cfg_cnt counters.
module pgm_ram_arb #(
  parameter int ADDR_W = pgm_pkg::ADDR_W,
  parameter int DATA_W = pgm_pkg::DATA_W,
  parameter int RAM_RD_LAT = 2,
  parameter int WR_FIFO_DEPTH = 4,
  parameter int STARVE_LIMIT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_in_en,
  input  logic [ADDR_W-1:0] wr_in_addr,
  input  logic [DATA_W-1:0] wr_in_data,
  output logic              wr_alf,
  output logic              wr_ovf_err,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_gnt,
  output logic              rd_rvalid,
  input  logic              cfg_rd_req,
  input  logic [ADDR_W-1:0] cfg_rd_addr,
  output logic              cfg_rd_gnt,
  output logic              cfg_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
`ifdef PGM_ARB_STAT_EN
  ,
  output logic [31:0]       stat_wr_cnt,
  output logic [31:0]       stat_rd_cnt,
  output logic [31:0]       stat_cfg_cnt
`endif
);
  import pgm_pkg::*;
  localparam int CW = $clog2(WR_FIFO_DEPTH) + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [ADDR_W-1:0] w_head_addr;
  logic [DATA_W-1:0] w_head_data;
  logic [CW-1:0] w_count;
  logic [WR_FIFO_DEPTH-1:0] w_match;
  logic w_force, w_pop;
  logic [SW-1:0] r_starve;
  logic [DATA_W-1:0] r_rdata;
  tag_e r_tag [RAM_RD_LAT+1];
  src_e w_src;
  tag_e w_tag;
  pgm_wr_fifo #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(WR_FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .i_push(wr_in_en),
    .i_addr(wr_in_addr),
    .i_data(wr_in_data),
    .i_pop(w_pop),
    .i_cmp_addr(rd_addr),
    .o_head_addr(w_head_addr),
    .o_head_data(w_head_data),
    .o_count(w_count),
    .o_match(w_match),
    .o_ovf(wr_ovf_err)
  );
  assign wr_alf = w_count >= CW'(WR_FIFO_DEPTH - 1);
  assign w_force = cfg_rd_req && r_starve == SW'(STARVE_LIMIT);
  // a fetch hitting a pending write falls through to the FIFO-drain rule until the hazard clears
  always_comb begin
    w_src = rst ? SRC_NONE : wr_alf ? SRC_WR : w_force ? SRC_CFG :
            (rd_req && ~|w_match) ? SRC_RD : (w_count != '0) ? SRC_WR :
            cfg_rd_req ? SRC_CFG : SRC_NONE;
    w_tag = w_src == SRC_RD ? TAG_RD : w_src == SRC_CFG ? TAG_CFG : TAG_NONE;
  end
  assign w_pop = w_src == SRC_WR;
  assign rd_gnt = w_src == SRC_RD;
  assign cfg_rd_gnt = w_src == SRC_CFG;
  assign rd_rvalid = r_tag[RAM_RD_LAT] == TAG_RD;
  assign cfg_rvalid = r_tag[RAM_RD_LAT] == TAG_CFG;
  assign rdata = r_rdata;
  // r_rdata captures ram_rdata one cycle before the tag reaches the last stage
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ram_en <= 1'b0;
      ram_we <= 1'b0;
      ram_addr <= '0;
      ram_wdata <= '0;
      r_rdata <= '0;
      r_starve <= '0;
      for (int i = 0; i <= RAM_RD_LAT; i++) r_tag[i] <= TAG_NONE;
    end else begin
      ram_en <= w_src != SRC_NONE;
      ram_we <= w_pop;
      ram_addr <= rd_gnt ? rd_addr : cfg_rd_gnt ? cfg_rd_addr : w_head_addr;
      ram_wdata <= w_head_data;
      r_rdata <= ram_rdata;
      r_starve <= (!cfg_rd_req || cfg_rd_gnt) ? '0 : r_starve + SW'(r_starve != SW'(STARVE_LIMIT));
      r_tag[0] <= w_tag;
      for (int i = 1; i <= RAM_RD_LAT; i++) r_tag[i] <= r_tag[i-1];
    end
`ifdef PGM_ARB_STAT_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      stat_wr_cnt <= '0;
      stat_rd_cnt <= '0;
      stat_cfg_cnt <= '0;
    end else begin
      stat_wr_cnt <= stat_wr_cnt + 32'(w_pop);
      stat_rd_cnt <= stat_rd_cnt + 32'(rd_gnt);
      stat_cfg_cnt <= stat_cfg_cnt + 32'(cfg_rd_gnt);
    end
`endif
endmodule
